// File: rtl/serial_adder_fsm_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master drives operands and consumes results; the slave is the adder.
interface serial_adder_fsm_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             V;

    modport master (
        output in_valid, A, B, Ci, Sub, out_ready,
        input  in_ready, out_valid, S, Co, V
    );

    modport slave (
        input  in_valid, A, B, Ci, Sub, out_ready,
        output in_ready, out_valid, S, Co, V
    );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-add cell, LSB first, one bit per clock.
// Results are registered and offered downstream under a valid/ready handshake.
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_fsm_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] op_a_reg, op_b_reg, acc_reg, s_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, cmsb_reg, co_reg, v_reg;
    logic             bit_s, bit_c, last_bit, accept;

    assign bit_s    = op_a_reg[0] ^ op_b_reg[0] ^ carry_reg;
    assign bit_c    = (op_a_reg[0] & op_b_reg[0]) | (op_a_reg[0] & carry_reg)
                    | (op_b_reg[0] & carry_reg);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so the inverted operand and a forced carry-in do the work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cmsb_reg  <= 1'b0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
            v_reg     <= 1'b0;
        end else if (accept) begin
            op_a_reg  <= bus.A;
            op_b_reg  <= bus.Sub ? ~bus.B : bus.B;
            carry_reg <= bus.Sub ? 1'b1 : bus.Ci;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            cmsb_reg  <= 1'b0;
        end else if (state_reg == RUN) begin
            acc_reg   <= {bit_s, acc_reg[WIDTH-1:1]};
            op_a_reg  <= {1'b0, op_a_reg[WIDTH-1:1]};
            op_b_reg  <= {1'b0, op_b_reg[WIDTH-1:1]};
            carry_reg <= bit_c;
            cnt_reg   <= cnt_reg + CW'(1);
            // Carry produced by bit WIDTH-2 is the carry into the MSB.
            if (cnt_reg == CW'(WIDTH - 2)) begin
                cmsb_reg <= bit_c;
            end
            if (last_bit) begin
                s_reg  <= {bit_s, acc_reg[WIDTH-1:1]};
                co_reg <= bit_c;
                v_reg  <= cmsb_reg ^ bit_c;
            end
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.S         = s_reg;
    assign bus.Co        = co_reg;
    assign bus.V         = v_reg;
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed-vector bench for serial_adder_fsm (WIDTH=8) with hand-computed results.
module tb_serial_adder_fsm;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    serial_adder_fsm_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_fsm #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for out_valid, counting clock edges; returns the count (or limit on timeout).
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sub,
                          input logic [7:0] es, input logic eco, input logic ev);
        int n;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.Ci = ci; bus.Sub = sub; bus.in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'(WIDTH));
        check({tag, "_S"},  32'(bus.S),  32'(es));
        check({tag, "_Co"}, 32'(bus.Co), 32'(eco));
        check({tag, "_V"},  32'(bus.V),  32'(ev));
        $display("txn %s: A=%02h B=%02h Ci=%0d Sub=%0d -> S=%02h Co=%0d V=%0d lat=%0d",
                 tag, a, b, ci, sub, bus.S, bus.Co, bus.V, n);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_back"},  32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        int n;
        logic [7:0] held_s;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Ci = 1'b0; bus.Sub = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_S",         32'(bus.S),         32'd0);
        rst_n = 1'b1;

        run_op("add_ovf", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);

        // Abort mid-RUN: outputs must clear immediately, without a clock edge.
        @(negedge clk);
        bus.A = 8'h12; bus.B = 8'h34; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_S",         32'(bus.S),         32'd0);
        check("abort_Co",        32'(bus.Co),        32'd0);
        check("abort_V",         32'(bus.V),         32'd0);
        $display("txn abort: S=%02h Co=%0d V=%0d", bus.S, bus.Co, bus.V);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("wrap",     8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("wrap_ci",  8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run_op("sub_neg",  8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure: 0x20+0x22=0x42 held through 5 stalled cycles with noisy inputs.
        @(negedge clk);
        bus.A = 8'h20; bus.B = 8'h22; bus.Ci = 1'b0; bus.Sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(n);
        check("bp_latency", 32'(n), 32'(WIDTH));
        held_s = bus.S;
        check("bp_S", 32'(held_s), 32'h42);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.A = bus.A + 8'h11;
            bus.B = bus.B ^ 8'hA5;
            @(posedge clk); #1;
            check("bp_hold_S",        32'(bus.S),         32'h42);
            check("bp_hold_Co",       32'(bus.Co),        32'd0);
            check("bp_hold_V",        32'(bus.V),         32'd0);
            check("bp_hold_valid",    32'(bus.out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(bus.in_ready),  32'd0);
        end
        $display("txn backpressure: S=%02h held 5 cycles", bus.S);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        check("bp_release_valid",    32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready),  32'd1);
        check("bp_release_S",        32'(bus.S),         32'h42);

        // Back-to-back with in_valid held high and out_ready held high.
        @(negedge clk);
        bus.A = 8'h03; bus.B = 8'h04; bus.Ci = 1'b0; bus.Sub = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.A = 8'h7F; bus.B = 8'h01;
        wait_done(n);
        check("b2b1_latency", 32'(n), 32'(WIDTH));
        check("b2b1_S", 32'(bus.S), 32'h07);
        check("b2b1_V", 32'(bus.V), 32'd0);
        $display("txn b2b1: S=%02h Co=%0d V=%0d", bus.S, bus.Co, bus.V);
        @(posedge clk); #1;
        check("b2b_gap_valid",    32'(bus.out_valid), 32'd0);
        check("b2b_gap_in_ready", 32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        check("b2b_accept2", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        wait_done(n);
        check("b2b2_latency", 32'(n), 32'(WIDTH));
        check("b2b2_S",  32'(bus.S),  32'h80);
        check("b2b2_Co", 32'(bus.Co), 32'd0);
        check("b2b2_V",  32'(bus.V),  32'd1);
        $display("txn b2b2: S=%02h Co=%0d V=%0d", bus.S, bus.Co, bus.V);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
